// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order instruction memory
// requests under a credit limit, buffers returned words with their PCs and
// hands them to decode over valid/ready. Redirects flush buffered and
// in-flight instructions.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pc_select_i,
    input  logic [31:0] pc_branch_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    // Program counter
    logic [31:0]   pc_q, pc_d;

    // In-flight queue: PC of every granted, unanswered request
    logic [31:0]   infl_pc_q [BUF_DEPTH];
    logic [PW-1:0] infl_wr_q, infl_wr_d;
    logic [PW-1:0] infl_rd_q, infl_rd_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    // Responses still to be discarded after a redirect
    logic [CW-1:0] drop_q, drop_d;

    // Instruction FIFO towards decode
    logic [31:0]   fifo_pc_q    [BUF_DEPTH];
    logic [31:0]   fifo_instr_q [BUF_DEPTH];
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    // Per-cycle events
    logic          pop;
    logic          rsp;
    logic          rsp_drop;
    logic          push;
    logic          gnt;
    logic [CW:0]   used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Decode handshake, credit check and qualification of bus events
    always_comb begin
        if_valid_o = (fifo_cnt_q != '0);
        pop        = if_valid_o & id_ready_i;
        // a response with nothing outstanding is an orphan and is ignored
        rsp        = imem_rvalid_i & (out_cnt_q != '0);
        rsp_drop   = rsp & (drop_q != '0);
        push       = rsp & ~rsp_drop & ~pc_select_i;
        used       = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
        // used - pop < BUF_DEPTH, rearranged to avoid underflow
        imem_req_o = reset_i & ~pc_select_i
                   & (used < ((CW+1)'(BUF_DEPTH) + (CW+1)'(pop)));
        gnt        = imem_req_o & imem_gnt_i;
    end

    assign imem_addr_o   = pc_q;
    assign if_instr_o    = fifo_instr_q[fifo_rd_q];
    assign if_pc_o       = fifo_pc_q[fifo_rd_q];
    assign if_pc_plus4_o = if_pc_o + 32'd4;

    // Next-state: counters move by the net change; a redirect overrides
    always_comb begin
        pc_d       = pc_q;
        infl_wr_d  = infl_wr_q;
        infl_rd_d  = infl_rd_q;
        out_cnt_d  = out_cnt_q + CW'(gnt) - CW'(rsp);
        drop_d     = drop_q - CW'(rsp_drop);
        fifo_wr_d  = push ? ptr_inc(fifo_wr_q) : fifo_wr_q;
        fifo_rd_d  = pop  ? ptr_inc(fifo_rd_q) : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

        if (gnt) begin
            infl_wr_d = ptr_inc(infl_wr_q);
            pc_d      = pc_q + 32'd4;
        end
        if (rsp) begin
            infl_rd_d = ptr_inc(infl_rd_q);
        end

        if (pc_select_i) begin
            pc_d       = pc_branch_i & 32'hFFFF_FFFC;
            fifo_rd_d  = fifo_wr_q;
            fifo_cnt_d = '0;
            // everything still in flight after this edge belongs to the old path
            drop_d     = out_cnt_q - CW'(rsp);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pc_q       <= RESET_PC;
            infl_wr_q  <= '0;
            infl_rd_q  <= '0;
            out_cnt_q  <= '0;
            drop_q     <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            infl_wr_q  <= infl_wr_d;
            infl_rd_q  <= infl_rd_d;
            out_cnt_q  <= out_cnt_d;
            drop_q     <= drop_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Queue and FIFO storage; cleared on reset so the head reads as zero
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                infl_pc_q[i]    <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            if (gnt) begin
                infl_pc_q[infl_wr_q] <= pc_q;
            end
            if (push) begin
                fifo_pc_q[fifo_wr_q]    <= infl_pc_q[infl_rd_q];
                fifo_instr_q[fifo_wr_q] <= imem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a randomized instruction memory drives
// the DUT while an epoch-tagged queue model predicts every output each cycle.
module tb_fetch_stage;

    localparam int unsigned DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sel;
    logic [31:0] branch;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;

    logic        a_req, a_valid, w_req, w_valid;
    logic [31:0] a_addr, a_instr, a_pc, a_pc4;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) u_dut (
        .clk_i(clk), .reset_i(reset_n), .pc_select_i(sel), .pc_branch_i(branch),
        .imem_req_o(a_req), .imem_addr_o(a_addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .if_valid_o(a_valid), .id_ready_i(ready), .if_instr_o(a_instr),
        .if_pc_o(a_pc), .if_pc_plus4_o(a_pc4)
    );

    fetch_stage #(.RESET_PC(WRAP_PC), .BUF_DEPTH(DEPTH)) u_wrap (
        .clk_i(clk), .reset_i(reset_n), .pc_select_i(sel), .pc_branch_i(branch),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .if_valid_o(w_valid), .id_ready_i(ready), .if_instr_o(w_instr),
        .if_pc_o(w_pc), .if_pc_plus4_o(w_pc4)
    );

    // Observed outputs of whichever instance is under test
    logic        use_wrap;
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_instr, o_pc, o_pc4;
    assign o_req   = use_wrap ? w_req   : a_req;
    assign o_valid = use_wrap ? w_valid : a_valid;
    assign o_addr  = use_wrap ? w_addr  : a_addr;
    assign o_instr = use_wrap ? w_instr : a_instr;
    assign o_pc    = use_wrap ? w_pc    : a_pc;
    assign o_pc4   = use_wrap ? w_pc4   : a_pc4;

    // Reference model: requests carry the path epoch they were fetched on;
    // a response survives only if its epoch is still current.
    typedef struct { logic [31:0] pc; int epoch; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    infl_t       m_infl[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pc;
    logic [31:0] m_reset_pc;
    int          m_epoch;

    // Memory environment
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    int          cyc;
    int          lat_min, lat_max;
    int          orphan_n;

    // Stimulus knobs
    int          p_gnt, p_ready, p_sel;
    bit          sel_once;
    logic [31:0] branch_once;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_infl.delete();
        m_fifo.delete();
        m_pc    = m_reset_pc;
        m_epoch = 0;
        mem_addr.delete();
        mem_due.delete();
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model
    task automatic step();
        bit   m_valid, m_pop, m_req, m_rsp, from_mem;
        ent_t head;
        infl_t e;
        @(negedge clk);
        sel    = sel_once ? 1'b1 : ($urandom_range(99) < p_sel);
        branch = sel_once ? branch_once : $urandom;
        sel_once = 1'b0;
        gnt    = ($urandom_range(99) < p_gnt);
        ready  = ($urandom_range(99) < p_ready);
        rvalid = 1'b0;
        rdata  = $urandom;
        from_mem = 1'b0;
        if (orphan_n > 0) begin
            rvalid = 1'b1;
            orphan_n--;
        end else if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            rvalid   = 1'b1;
            rdata    = mem_addr[0] ^ 32'hA5A5_0000;
            from_mem = 1'b1;
        end
        #1;
        m_valid = (m_fifo.size() != 0);
        m_pop   = m_valid && ready;
        m_req   = !sel && (m_infl.size() + m_fifo.size() - int'(m_pop) < int'(DEPTH));
        check("req", o_req, m_req);
        check("addr", o_addr, m_pc);
        check("valid", o_valid, m_valid);
        if (m_valid) begin
            head = m_fifo[0];
            check("pc", o_pc, head.pc);
            check("instr", o_instr, head.instr);
            check("pc_plus4", o_pc4, head.pc + 32'd4);
        end
        // memory reacts to what the DUT actually does
        if (from_mem) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end
        if (o_req && gnt) begin
            mem_addr.push_back(o_addr);
            mem_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        end
        // model update
        m_rsp = rvalid && (m_infl.size() > 0);
        if (m_pop) void'(m_fifo.pop_front());
        if (m_rsp) begin
            e = m_infl.pop_front();
            if (e.epoch == m_epoch && !sel)
                m_fifo.push_back('{pc: e.pc, instr: rdata});
        end
        if (sel) begin
            m_fifo.delete();
            m_epoch++;
            m_pc = branch & 32'hFFFF_FFFC;
        end else if (m_req && gnt) begin
            m_infl.push_back('{pc: m_pc, epoch: m_epoch});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        sel = 1'b0; branch = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    endtask

    initial begin
        int waited;
        n_tests = 0; n_fail = 0; cyc = 0; orphan_n = 0;
        use_wrap = 1'b0; sel_once = 1'b0; branch_once = '0;
        p_gnt = 100; p_ready = 100; p_sel = 0; lat_min = 1; lat_max = 1;
        reset_n = 1'b0;
        idle_inputs();
        m_reset_pc = 32'h0000_0000;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", o_req, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_addr", o_addr, 32'h0000_0000);
        check("rst_instr", o_instr, 32'h0000_0000);
        check("rst_pc", o_pc, 32'h0000_0000);
        check("rst_pc4", o_pc4, 32'h0000_0004);
        @(negedge clk) reset_n = 1'b1;
        #1 check("first_req", o_req, 1'b1);

        // streaming with 1-cycle memory
        repeat (20) step();

        // decode backpressure, then release
        p_ready = 0;
        repeat (10) step();
        p_ready = 100;
        repeat (10) step();

        // redirect with two requests in flight on 3-cycle memory
        lat_min = 3; lat_max = 3;
        waited = 0;
        while (m_infl.size() != 2 && waited < 20) begin
            step();
            waited++;
        end
        check("redir_setup_inflight", m_infl.size(), 2);
        sel_once = 1'b1; branch_once = 32'h0000_0103;
        step();
        #1 check("redir_addr", o_addr, 32'h0000_0100);
        repeat (15) step();

        // redirect coinciding with a response and a decode transfer
        lat_min = 1; lat_max = 1;
        repeat (8) step();
        sel_once = 1'b1; branch_once = 32'h0000_2000;
        step();
        #1 check("redir_fifo_empty", o_valid, 1'b0);
        repeat (10) step();

        // randomized traffic
        p_gnt = 70; p_ready = 60; p_sel = 5; lat_min = 1; lat_max = 3;
        repeat (1500) step();

        // asynchronous reset during a stall
        p_gnt = 100; p_ready = 100; p_sel = 0; lat_min = 3; lat_max = 3;
        repeat (8) step();
        p_ready = 0;
        repeat (2) step();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", o_valid, 1'b0);
        check("async_rst_req", o_req, 1'b0);
        orphan_n = mem_addr.size() + 1;
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1 check("restart_addr", o_addr, 32'h0000_0000);
        p_gnt = 0; p_ready = 100; lat_min = 1; lat_max = 1;
        waited = 0;
        while (orphan_n > 0 && waited < 10) begin
            step();
            waited++;
        end
        repeat (2) step();
        p_gnt = 100;
        repeat (20) step();

        // PC wrap on the second instance
        reset_n = 1'b0;
        idle_inputs();
        use_wrap = 1'b1;
        m_reset_pc = WRAP_PC;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("wrap_rst_addr", o_addr, WRAP_PC);
        @(negedge clk) reset_n = 1'b1;
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage pipeline. Owns the program counter, issues in-order requests to instruction memory over a request/grant, response-valid bus, and buffers returned words with their PCs in a small FIFO. It presents them to the decode stage through a valid/ready handshake. It accepts branch redirects (`pc_select`/`pc_branch`) from the execute stage and discards every in-flight and buffered instruction on a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `BUF_DEPTH`, default 2: instruction FIFO entries. Also the credit limit on outstanding requests plus buffered entries. Legal range ≥ 2.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `pc_select_i`  in  1  redirect request from execute.
- `pc_branch_i`  in  32  redirect target. Bits [1:0] are ignored and treated as 0.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  32  fetch address, equal to the current PC.
- `imem_gnt_i`  in  1  request accepted this cycle; meaningful only when `imem_req_o`=1.
- `imem_rvalid_i`  in  1  response word valid. Responses return in order, at least 1 cycle after their grant.
- `imem_rdata_i`  in  32  instruction word.
- `if_valid_o`  out  1  decode-side entry valid (FIFO non-empty).
- `id_ready_i`  in  1  decode accepts the entry this cycle.
- `if_instr_o`  out  32  instruction at the FIFO head.
- `if_pc_o`  out  32  PC of the head entry.
- `if_pc_plus4_o`  out  32  `if_pc_o` + 4, modulo 2^32.

## Operation
- **State.**
  - `pc` (32 bits).
  - In-flight PC queue (BUF_DEPTH entries). Holds the address of each granted, unanswered request.
  - Instruction FIFO (BUF_DEPTH entries of {pc, instr}).
  - `outstanding` counter (0..BUF_DEPTH).
  - `drop` counter (0..BUF_DEPTH).
- **Request issue.**
  - `imem_req_o` = `reset_i` & !`pc_select_i` & (`outstanding` + `fifo_count` − `pop` < BUF_DEPTH).
  - `pop` = `if_valid_o` & `id_ready_i`.
- **Grant.** On a grant:
  - push `pc` into the in-flight queue;
  - `pc` ← `pc` + 4, wrapping modulo 2^32;
  - increment `outstanding`.
- **Response.** On `imem_rvalid_i`:
  - pop the in-flight queue and decrement `outstanding`;
  - if `drop` > 0, discard the word and decrement `drop`;
  - otherwise push {queued pc, `imem_rdata_i`} into the FIFO.
- **Orphan response.** `imem_rvalid_i` with `outstanding`=0 is a protocol violation and is ignored; no state changes.
- **Decode handshake.**
  - The head entry transfers when `if_valid_o` & `id_ready_i`.
  - Outputs hold steady while `if_valid_o`=1 and `id_ready_i`=0.
- **Redirect** (`pc_select_i`=1), all in the same edge:
  - `pc` ← {`pc_branch_i`[31:2], 2'b00};
  - FIFO cleared;
  - `drop` ← `outstanding` − `imem_rvalid_i`, so a response arriving in the redirect cycle is discarded too;
  - no request is issued.
  - A decode transfer coinciding with the redirect counts as completed; the decode stage flushes it.
- **Back-to-back redirects.** The last redirect wins. `drop` is recomputed each time and never exceeds BUF_DEPTH.
- **Simultaneous events.** Grant, response and pop may all occur in one cycle. Counters are updated by the net change.

## Timing
- **Reset values** (reset_i low):
  - `pc`=RESET_PC;
  - FIFO, in-flight queue, `outstanding` and `drop` all empty/0;
  - `if_valid_o`=0, `imem_req_o`=0;
  - `imem_addr_o`=RESET_PC;
  - `if_instr_o`/`if_pc_o`=0, `if_pc_plus4_o`=4.
  - Reset asserted mid-operation aborts everything immediately. Responses arriving after reset deassertion for pre-reset requests are orphans and are ignored.
- **First request.** `imem_req_o`=1 in the first cycle after reset deasserts.
- **Fetch latency.** Grant in cycle N with response in N+1 gives `if_valid_o`=1 in N+2.
- **Throughput.** With 1-cycle memory and `id_ready_i` held high: one instruction per cycle.
- **Redirect latency.** Redirect in cycle N → request to the target in N+1 → earliest target `if_valid_o` in N+3.
- **Backpressure.** If decode stalls, requests stop once `outstanding` + `fifo_count` = BUF_DEPTH. No response is ever lost.

## Test plan
- **Reset and stream.** Release reset; memory answers 1 cycle after grant with word = addr ^ 32'hA5A5_0000; `id_ready_i`=1 → `if_pc_o` = 0, 4, 8, … on consecutive cycles starting 2 cycles after the first grant, with matching instructions.
- **Backpressure.** Hold `id_ready_i`=0 for 10 cycles mid-stream → exactly 2 requests outstanding or buffered. `if_pc_o` stays constant. On release, sequence resumes with no gap or duplicate.
- **Redirect with drops.** Use 3-cycle memory latency. Assert `pc_select_i` with `pc_branch_i`=32'h0000_0103 while 2 requests are in flight → both late responses are discarded; `imem_addr_o`=32'h0000_0100 next cycle; the first delivered `if_pc_o` is 32'h0000_0100.
- **Redirect coincident with response and pop.** Redirect in the same cycle as `imem_rvalid_i` and a decode transfer → the response is dropped; FIFO is empty next cycle; `drop` equals remaining in-flight count.
- **PC wrap.** `RESET_PC`=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; `if_pc_plus4_o` of FFFF_FFFC is 0.
- **Async reset mid-burst.** Drive `reset_i` low between clock edges during a stall → `if_valid_o` and `imem_req_o` drop immediately; after release, fetch restarts at RESET_PC and orphan responses are ignored.
